// File: rtl/req_cap_pkg.sv
// Shared types and helpers for request_capture: FSM state encoding and the
// debounce counter width calculation.
package req_cap_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Counter must reach DEBOUNCE_CYCLES-1; the +1 keeps one-cycle debounce at 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One request line: 2-flop synchronizer, debounce to a stable level, and a
// single-cycle pulse when the stable level rises.
module debounce_cell
    import req_cap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            // Any sample matching the stable level restarts the run.
            if (r_sync2 != r_stable) begin
                if (r_cnt == LAST) begin
                    r_stable <= r_sync2;
                    r_rise   <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/request_capture.sv
// Debounced request capture with sticky pending bits and a present/ack FSM
// that hands the highest-index pending request to a consumer one at a time.
// Optional feature: define REQ_CAP_OVF_EN to add the sticky ovf_o output.
module request_capture
    import req_cap_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_i,
    input  logic         ack_i,
    output logic [N-1:0] onehot_o,
    output logic         valid_o,
    output logic [N-1:0] pending_o
`ifdef REQ_CAP_OVF_EN
    ,
    output logic         ovf_o
`endif
);

    if (N < 2) begin : g_chk_n
        $error("request_capture: N must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
        $error("request_capture: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N-1:0] w_rise;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_top;

    state_t       r_state;
    logic [N-1:0] r_pending;
    logic [N-1:0] r_onehot;
    logic         r_valid;

    for (genvar g = 0; g < N; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn_i[g]),
            .rise_o (w_rise[g])
        );
    end

    always_comb begin
        w_clr = '0;
        if (r_state == PRESENT && ack_i) begin
            w_clr = r_onehot;
        end
    end

    // Ascending scan, so the highest set bit is the last one written.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < N; i++) begin
            if (r_pending[i]) begin
                w_top = N'(1) << i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_onehot  <= '0;
            r_valid   <= 1'b0;
        end else begin
            // A rise on the bit being acked keeps it pending.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            case (r_state)
                IDLE: begin
                    if (|r_pending) begin
                        r_onehot <= w_top;
                        r_valid  <= 1'b1;
                        r_state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_i) begin
                        r_onehot <= '0;
                        r_valid  <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_onehot <= '0;
                    r_valid  <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

`ifdef REQ_CAP_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (|(w_rise & r_pending & ~w_clr)) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf_o = r_ovf;
`endif

    assign onehot_o  = r_onehot;
    assign valid_o   = r_valid;
    assign pending_o = r_pending;

endmodule

// File: tb/tb_request_capture.sv
// Scenario and randomized bench for request_capture against a window-based
// behavioural model (checks ovf_o too when REQ_CAP_OVF_EN is defined).
module tb_request_capture;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_i = '0;
    logic         ack_i = 1'b0;
    logic [N-1:0] onehot_o;
    logic         valid_o;
    logic [N-1:0] pending_o;
`ifdef REQ_CAP_OVF_EN
    logic         ovf_o;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    request_capture #(
        .N               (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_i     (btn_i),
        .ack_i     (ack_i),
        .onehot_o  (onehot_o),
        .valid_o   (valid_o),
        .pending_o (pending_o)
`ifdef REQ_CAP_OVF_EN
        ,
        .ovf_o     (ovf_o)
`endif
    );

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_s1, m_s2, m_stable, m_rise, m_pending, m_onehot, m_clr;
    logic         m_valid;
    logic [D-1:0] m_win [N];
`ifdef REQ_CAP_OVF_EN
    logic         m_ovf;
`endif

    function automatic logic [N-1:0] highest(input logic [N-1:0] p);
        for (int i = N - 1; i >= 0; i--) begin
            if (p[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0;
            m_pending = '0; m_onehot = '0; m_valid = 1'b0;
            for (int b = 0; b < N; b++) m_win[b] = '0;
`ifdef REQ_CAP_OVF_EN
            m_ovf = 1'b0;
`endif
        end else begin
            m_clr = (m_valid && ack_i) ? m_onehot : '0;
`ifdef REQ_CAP_OVF_EN
            if ((m_rise & m_pending & ~m_clr) != '0) m_ovf = 1'b1;
`endif
            if (!m_valid) begin
                if (m_pending != '0) begin
                    m_onehot = highest(m_pending);
                    m_valid  = 1'b1;
                end
            end else if (ack_i) begin
                m_onehot = '0;
                m_valid  = 1'b0;
            end
            m_pending = (m_pending & ~m_clr) | m_rise;
            // stable level flips once the last D synchronized samples all disagree with it
            for (int b = 0; b < N; b++) begin
                m_win[b]  = {m_win[b][D-2:0], m_s2[b]};
                m_rise[b] = 1'b0;
                if (m_win[b] == {D{~m_stable[b]}}) begin
                    m_stable[b] = ~m_stable[b];
                    m_rise[b]   = m_stable[b];
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_i;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; btn_i = '0; ack_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_o, onehot_o, pending_o} !== '0)
            $display("FAIL reset_state: got v=%b oh=%b p=%b, expected all zero", valid_o, onehot_o, pending_o);
`ifdef REQ_CAP_OVF_EN
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, expected 0", ovf_o); end
`endif
        if ({valid_o, onehot_o, pending_o} !== '0) errors++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_press();
        btn_i = 4'b0100;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (valid_o !== (k >= 8) || onehot_o !== ((k >= 8) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL single_latency edge %0d: got v=%b oh=%b, expected v=%b", k, valid_o, onehot_o, (k >= 8));
            end
        end
        btn_i = '0;
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || onehot_o !== '0 || pending_o !== '0) begin
            errors++;
            $display("FAIL single_ack: got v=%b oh=%b p=%b, expected 0/0000/0000", valid_o, onehot_o, pending_o);
        end
        // ack while idle must be ignored
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        repeat (D + 4) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || pending_o !== '0) begin
            errors++;
            $display("FAIL idle_ack: got v=%b p=%b, expected 0/0000", valid_o, pending_o);
        end
    endtask

    task automatic test_bounce();
        bit bad = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 6) btn_i[1] = ~btn_i[1];
            @(negedge clk);
            if (pending_o !== '0 || valid_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || btn_i !== '0) begin
            errors++;
            $display("FAIL bounce: pending went nonzero (now p=%b v=%b), expected 0000", pending_o, valid_o);
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] exp_oh [3];
        bit ok;
        exp_oh[0] = 4'b1000; exp_oh[1] = 4'b0010; exp_oh[2] = 4'b0001;
        btn_i = 4'b1011;
        wait_valid(30, ok);
        btn_i = '0;
        checks++;
        if (!ok) begin errors++; $display("FAIL simul_timeout: valid never rose, expected 1"); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_o !== 1'b1 || onehot_o !== exp_oh[i]) begin
                errors++;
                $display("FAIL simul_order %0d: got v=%b oh=%b, expected 1/%b", i, valid_o, onehot_o, exp_oh[i]);
            end
            ack_i = 1'b1;
            @(negedge clk);
            ack_i = 1'b0;
            checks++;
            if (valid_o !== 1'b0 || onehot_o !== '0) begin
                errors++;
                $display("FAIL simul_gap %0d: got v=%b oh=%b, expected 0/0000", i, valid_o, onehot_o);
            end
            if (i < 2) @(negedge clk);
        end
        checks++;
        if (pending_o !== '0) begin
            errors++;
            $display("FAIL simul_drain: got p=%b, expected 0000", pending_o);
        end
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_set_wins();
        bit ok;
        btn_i = 4'b0100;
        wait_valid(30, ok);
        btn_i = '0;
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || valid_o !== 1'b1 || onehot_o !== 4'b0100) begin
            errors++;
            $display("FAIL setwins_hold: got v=%b oh=%b, expected 1/0100", valid_o, onehot_o);
        end
        btn_i = 4'b0100;
        repeat (6) @(negedge clk);
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        checks++;
        if (pending_o[2] !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL setwins_pending: got p=%b v=%b, expected p[2]=1 v=0", pending_o, valid_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || onehot_o !== 4'b0100) begin
            errors++;
            $display("FAIL setwins_represent: got v=%b oh=%b, expected 1/0100", valid_o, onehot_o);
        end
        btn_i = '0;
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_absorb();
        bit ok;
        btn_i = 4'b0001;
        wait_valid(30, ok);
        btn_i = '0;
        repeat (10) @(negedge clk);
        btn_i = 4'b0001;
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || pending_o !== 4'b0001 || onehot_o !== 4'b0001 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL absorb_state: got p=%b oh=%b v=%b, expected 0001/0001/1", pending_o, onehot_o, valid_o);
        end
`ifdef REQ_CAP_OVF_EN
        repeat (5) @(negedge clk);
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, expected 1", ovf_o); end
`endif
        btn_i = '0;
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || pending_o !== '0) begin
            errors++;
            $display("FAIL absorb_no_repeat: got v=%b p=%b, expected 0/0000", valid_o, pending_o);
        end
`ifdef REQ_CAP_OVF_EN
        checks++;
        if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", ovf_o); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit bad = 1'b0;
        btn_i = 4'b1000;
        wait_valid(30, ok);
        btn_i = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || valid_o !== 1'b0 || pending_o !== '0 || onehot_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b oh=%b p=%b, expected all zero", valid_o, onehot_o, pending_o);
        end
`ifdef REQ_CAP_OVF_EN
        checks++;
        if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_mid_ovf: got %b, expected 0", ovf_o); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (valid_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_quiet: got valid after reset, expected 0"); end
        // button already high across reset release registers as a press
        rst_n = 1'b0;
        btn_i = 4'b0010;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(20, ok);
        checks++;
        if (!ok || onehot_o !== 4'b0010) begin
            errors++;
            $display("FAIL reset_held: got v=%b oh=%b, expected 1/0010", valid_o, onehot_o);
        end
        btn_i = '0;
        ack_i = 1'b1;
        @(negedge clk);
        ack_i = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] pattern = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) pattern = N'($urandom);
            btn_i = pattern;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) btn_i[b] = ~btn_i[b];
            end
            ack_i = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if (valid_o !== m_valid || onehot_o !== m_onehot || pending_o !== m_pending) begin
                errors++;
                $display("FAIL random cyc %0d: got v=%b oh=%b p=%b, expected v=%b oh=%b p=%b",
                         c, valid_o, onehot_o, pending_o, m_valid, m_onehot, m_pending);
            end
`ifdef REQ_CAP_OVF_EN
            checks++;
            if (ovf_o !== m_ovf) begin
                errors++;
                $display("FAIL random_ovf cyc %0d: got %b, expected %b", c, ovf_o, m_ovf);
            end
`endif
        end
        btn_i = '0;
        ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_set_wins();
        test_absorb();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/request_capture.md
REQUEST_CAPTURE -- requirements
Module: request_capture

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of request lines (N >= 2).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive stable cycles needed to accept a level change (>= 1).
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the port btn_i, input, N bits: raw asynchronous request lines, active-high.
REQ-006 The block SHALL have the port ack_i, input, 1 bit: consumer acknowledges the presented request.
REQ-007 The block SHALL have the port onehot_o, output, N bits: the presented request, exactly one bit set when valid, else all zero; it drives the priority encoder input.
REQ-008 The block SHALL have the port valid_o, output, 1 bit: onehot_o holds a request.
REQ-009 The block SHALL have the port pending_o, output, N bits: sticky captured requests not yet acknowledged.

Function
REQ-010 Each btn_i bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 A per-bit stable level SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the stable value restarts the count.
REQ-012 A 0->1 transition of a stable level SHALL set the matching pending bit on the next edge; a 1->0 transition SHALL have no effect.
REQ-013 The FSM SHALL have two states, IDLE and PRESENT.
REQ-014 In IDLE with pending nonzero, the FSM SHALL latch onehot_o to the highest-index pending bit, assert valid_o, and enter PRESENT on the same edge.
REQ-015 In PRESENT, onehot_o and valid_o SHALL hold unchanged regardless of new pending bits until ack_i is sampled high.
REQ-016 On ack_i in PRESENT, the FSM SHALL clear the presented pending bit, zero onehot_o, deassert valid_o, and return to IDLE; a new presentation follows no earlier than the next cycle.
REQ-017 ack_i sampled in IDLE SHALL be ignored.
REQ-018 If a new rising edge of the presented bit coincides with its ack, the pending bit SHALL remain set (set wins).
REQ-019 A rising edge on an already-pending bit SHALL be absorbed, with no count and no error unless REQ_CAP_OVF_EN is defined.
REQ-020 Latency from a clean btn_i rise to valid_o SHALL be 2 (sync) + DEBOUNCE_CYCLES + 2 cycles from an idle block.

Reset
REQ-021 While rst_n is low, the following SHALL be held: state IDLE, onehot_o = 0, valid_o = 0, pending_o = 0, synchronizers and stable levels = 0, counters = 0.
REQ-022 Reset asserted mid-PRESENT SHALL drop valid_o immediately and discard all pending requests.
REQ-023 After reset release, a button already held high SHALL register as a rising edge once debounced.

Configuration
REQ-024 With REQ_CAP_OVF_EN defined, the block SHALL add an output ovf_o (1 bit, sticky, reset 0) set when a rising edge hits an already-pending bit, and cleared only by reset.
REQ-025 Without REQ_CAP_OVF_EN, ovf_o and its logic SHALL be absent.

Structure
REQ-026 The package req_cap_pkg SHALL hold the FSM state enum (IDLE, PRESENT) and a function for the debounce counter width, $clog2(DEBOUNCE_CYCLES+1).
REQ-027 Synchronizer plus debounce per bit SHALL be the sub-module debounce_cell, instantiated N times by a generate loop; capture and FSM stay in request_capture.

Verification
REQ-028 The bench SHALL cover a single press: btn_i = 4'b0100 held for 10 cycles -> valid_o = 1, onehot_o = 4'b0100 after 8 cycles; ack_i pulse -> onehot_o = 0, pending_o = 0.
REQ-029 The bench SHALL cover a bounce: btn_i[1] toggles every cycle for 6 cycles then returns low -> pending_o stays 4'b0000.
REQ-030 The bench SHALL cover simultaneous presses: btn_i = 4'b1011 -> presents 4'b1000, then 4'b0010, then 4'b0001 on successive acks, with one idle cycle between each.
REQ-031 The bench SHALL cover set-wins: a debounced rise of bit 2 lands on the same edge as the ack of bit 2 -> pending_o[2] stays 1 and bit 2 is re-presented next cycle.
REQ-032 The bench SHALL cover reset mid-operation: rst_n low while valid_o = 1 -> valid_o = 0 and pending_o = 0 immediately, with no presentation until a new debounced press.
REQ-033 The bench SHALL cover overflow with REQ_CAP_OVF_EN defined: a second press of bit 0 while bit 0 is still pending -> ovf_o = 1 and held.
